// File: rtl/fpr_cdb_arbiter.sv
// Round-robin responder for the FPR common data bus: grants one FP unit result per
// cycle and registers the winner's tag/data onto the CDB one cycle later.
module fpr_cdb_arbiter #(
    parameter int N_REQ     = 4,
    parameter int ROB_WIDTH = 6
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*ROB_WIDTH-1:0] req_tag,
    input  logic [N_REQ*32-1:0]        req_data,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       cdb_valid,
    output logic [ROB_WIDTH-1:0]       cdb_tag,
    output logic [31:0]                cdb_data
);

    localparam int unsigned   NR   = N_REQ;
    localparam int            PW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [PW-1:0] LAST = PW'(N_REQ - 1);

    logic [PW-1:0]        ptr;
    logic [PW-1:0]        ptr_next;
    logic [PW-1:0]        grant_idx;
    logic [PW-1:0]        cand;
    logic                 grant;
    int unsigned          pos;
    logic [ROB_WIDTH-1:0] tag_arr  [N_REQ];
    logic [31:0]          data_arr [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign tag_arr[g]  = req_tag[g*ROB_WIDTH +: ROB_WIDTH];
        assign data_arr[g] = req_data[g*32 +: 32];
    end

    // Scan ptr, ptr+1, ... with an explicit wrap so non-power-of-two N_REQ works.
    always_comb begin
        grant     = 1'b0;
        grant_idx = '0;
        cand      = '0;
        pos       = 0;
        for (int unsigned k = 0; k < NR; k++) begin
            pos = 32'(ptr) + k;
            if (pos >= NR) begin
                pos = pos - NR;
            end
            cand = PW'(pos);
            if (!grant && req_valid[cand]) begin
                grant     = 1'b1;
                grant_idx = cand;
            end
        end
        if (reset) begin
            grant = 1'b0;
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        ptr_next = (grant_idx == LAST) ? '0 : grant_idx + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr       <= '0;
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_data  <= '0;
        end else begin
            cdb_valid <= grant;
            if (grant) begin
                ptr      <= ptr_next;
                cdb_tag  <= tag_arr[grant_idx];
                cdb_data <= data_arr[grant_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert ($onehot0(req_ready));
            assert ((req_ready & ~req_valid) == '0);
        end
    end

endmodule

// File: tb/tb_fpr_cdb_arbiter.sv
// Bench for fpr_cdb_arbiter: a table of handshake cycles plus a random phase, with
// CDB broadcasts checked one cycle later against a scoreboard queue.
module tb_fpr_cdb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [15:0] req_tag;
    logic [127:0] req_data;
    logic [3:0]  req_ready;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_data;

    fpr_cdb_arbiter #(.N_REQ(4), .ROB_WIDTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_tag   (req_tag),
        .req_data  (req_data),
        .req_ready (req_ready),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] valid;
        logic [3:0] ready;
        int         ptr;
        logic       ovr;
    } vec_t;

    typedef struct {
        logic        valid;
        logic [3:0]  tag;
        logic [31:0] data;
    } bc_t;

    bc_t         sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [3:0]  tag_a  [4];
    logic [31:0] data_a [4];
    vec_t        vecs   [28];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one cycle, checks the combinational grant mid-cycle and the CDB result
    // of the previous cycle, then queues this cycle's expected broadcast.
    task automatic run_cycle(input logic rst, input logic [3:0] v,
                             input logic [3:0] exp_rdy, input int exp_ptr);
        bc_t e;
        bc_t nx;
        reset     = rst;
        req_valid = v;
        req_tag   = {tag_a[3], tag_a[2], tag_a[1], tag_a[0]};
        req_data  = {data_a[3], data_a[2], data_a[1], data_a[0]};
        @(negedge clk);
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        if (exp_ptr >= 0) begin
            chk("ptr", 32'(dut.ptr), 32'(exp_ptr));
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("cdb_valid", 32'(cdb_valid), 32'(e.valid));
            if (e.valid) begin
                chk("cdb_tag", 32'(cdb_tag), 32'(e.tag));
                chk("cdb_data", cdb_data, e.data);
            end
        end
        nx.valid = 1'b0;
        nx.tag   = '0;
        nx.data  = '0;
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                if (exp_rdy[i]) begin
                    nx.valid = 1'b1;
                    nx.tag   = tag_a[i];
                    nx.data  = data_a[i];
                end
            end
        end
        sb.push_back(nx);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic       rst;
        logic [3:0] v;
        logic [3:0] exp_r;
        int         ptr_m;
        int         win;
        int         idx;

        reset     = 1'b1;
        req_valid = '0;
        req_tag   = '0;
        req_data  = '0;

        //            rst   valid    ready    ptr ovr
        vecs[0]  = '{1'b1, 4'b1111, 4'b0000, -1, 1'b0};
        vecs[1]  = '{1'b0, 4'b0000, 4'b0000,  0, 1'b0};
        vecs[2]  = '{1'b0, 4'b0000, 4'b0000,  0, 1'b0};
        vecs[3]  = '{1'b0, 4'b0000, 4'b0000,  0, 1'b0};
        vecs[4]  = '{1'b0, 4'b0100, 4'b0100,  0, 1'b1};
        vecs[5]  = '{1'b0, 4'b0000, 4'b0000,  3, 1'b0};
        vecs[6]  = '{1'b0, 4'b0000, 4'b0000,  3, 1'b0};
        vecs[7]  = '{1'b1, 4'b0000, 4'b0000,  3, 1'b0};
        vecs[8]  = '{1'b0, 4'b1111, 4'b0001,  0, 1'b0};
        vecs[9]  = '{1'b0, 4'b1111, 4'b0010,  1, 1'b0};
        vecs[10] = '{1'b0, 4'b1111, 4'b0100,  2, 1'b0};
        vecs[11] = '{1'b0, 4'b1111, 4'b1000,  3, 1'b0};
        vecs[12] = '{1'b0, 4'b1111, 4'b0001,  0, 1'b0};
        vecs[13] = '{1'b0, 4'b1111, 4'b0010,  1, 1'b0};
        vecs[14] = '{1'b0, 4'b1111, 4'b0100,  2, 1'b0};
        vecs[15] = '{1'b0, 4'b1111, 4'b1000,  3, 1'b0};
        vecs[16] = '{1'b0, 4'b0100, 4'b0100,  0, 1'b0};
        vecs[17] = '{1'b0, 4'b0011, 4'b0001,  3, 1'b0};
        vecs[18] = '{1'b0, 4'b0011, 4'b0010,  1, 1'b0};
        vecs[19] = '{1'b0, 4'b1000, 4'b1000,  2, 1'b0};
        vecs[20] = '{1'b0, 4'b0101, 4'b0001,  0, 1'b0};
        vecs[21] = '{1'b0, 4'b0110, 4'b0010,  1, 1'b0};
        vecs[22] = '{1'b0, 4'b0101, 4'b0100,  2, 1'b0};
        vecs[23] = '{1'b0, 4'b0000, 4'b0000,  3, 1'b0};
        vecs[24] = '{1'b0, 4'b1000, 4'b1000,  3, 1'b0};
        vecs[25] = '{1'b1, 4'b1000, 4'b0000,  0, 1'b0};
        vecs[26] = '{1'b0, 4'b0000, 4'b0000,  0, 1'b0};
        vecs[27] = '{1'b0, 4'b0000, 4'b0000,  0, 1'b0};

        for (int r = 0; r < 28; r++) begin
            for (int i = 0; i < 4; i++) begin
                tag_a[i]  = vecs[r].ovr ? 4'd5 : 4'(i);
                data_a[i] = vecs[r].ovr ? 32'h3F80_0000 : {8'hA0, 8'(r), 8'h00, 8'(i)};
            end
            run_cycle(vecs[r].rst, vecs[r].valid, vecs[r].ready, vecs[r].ptr);
        end

        // Random traffic against a round-robin reference model.
        ptr_m = 0;
        repeat (60) begin
            rst   = ($urandom_range(0, 15) == 0);
            v     = 4'($urandom_range(0, 15));
            exp_r = '0;
            win   = 0;
            if (!rst) begin
                for (int k = 0; k < 4; k++) begin
                    idx = (ptr_m + k) % 4;
                    if (v[idx] && exp_r == 4'b0000) begin
                        exp_r[idx] = 1'b1;
                        win        = idx;
                    end
                end
            end
            for (int i = 0; i < 4; i++) begin
                tag_a[i]  = 4'($urandom);
                data_a[i] = $urandom;
            end
            run_cycle(rst, v, exp_r, ptr_m);
            if (rst) begin
                ptr_m = 0;
            end else if (exp_r != 4'b0000) begin
                ptr_m = (win + 1) % 4;
            end
        end

        run_cycle(1'b0, 4'b0000, 4'b0000, ptr_m);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
